// File: rtl/grayscale_packer_pkg.sv
// Shared constants, FSM encoding and the RGB565-to-gray helper for grayscale_packer_ise.
// Optional macro: GRAYSCALE_PACKER_ROUND_EN selects round-to-nearest gray instead of truncation.
package grayscale_packer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PIX_W  = 16;
    localparam int unsigned GRAY_W = 8;
    localparam int unsigned CNT_W  = 8;

    // Opcode field lives in valueB[31:30]
    localparam logic [1:0] OP_PUSH   = 2'b00;
    localparam logic [1:0] OP_POP    = 2'b01;
    localparam logic [1:0] OP_STATUS = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    // Luma weights scaled by 256
    localparam int unsigned W_R = 54;
    localparam int unsigned W_G = 183;
    localparam int unsigned W_B = 19;

    // STATUS word layout; count occupies [7:0]
    localparam int unsigned ST_PENDING   = 8;
    localparam int unsigned ST_FULL      = 9;
    localparam int unsigned ST_EMPTY     = 10;
    localparam int unsigned ST_OVERFLOW  = 11;
    localparam int unsigned ST_UNDERFLOW = 12;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_WRITE   = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // Weighted sum of the expanded channels; the 16-bit sum cannot overflow (max 64220, 64348 rounded)
    function automatic logic [GRAY_W-1:0] rgb565_to_gray(input logic [PIX_W-1:0] pix);
        logic [7:0]  r8;
        logic [7:0]  g8;
        logic [7:0]  b8;
        logic [15:0] sum;
        r8  = {pix[15:11], 3'b000};
        g8  = {pix[10:5], 2'b00};
        b8  = {pix[4:0], 3'b000};
        sum = 16'(16'(r8) * 16'(W_R)) + 16'(16'(g8) * 16'(W_G)) + 16'(16'(b8) * 16'(W_B));
`ifdef GRAYSCALE_PACKER_ROUND_EN
        sum = sum + 16'd128;
`else
        sum = sum;
`endif
        return sum[15:8];
    endfunction

endpackage

// File: rtl/gray_word_fifo.sv
// Synchronous 32-bit word FIFO; push on full and pop on empty are no-ops, pointers wrap modulo DEPTH.
module gray_word_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic [7:0]  o_count,
    output logic        o_full,
    output logic        o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [7:0]    r_count;
    logic [31:0]   r_mem [DEPTH];
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == 8'(DEPTH));
    assign o_empty   = (r_count == 8'd0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_clear;
    assign w_do_pop  = i_pop && !o_empty && !i_clear;

    // Storage array, written only on an accepted push
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 8'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 8'd1;
                2'b01:   r_count <= r_count - 8'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/grayscale_packer_ise.sv
// Custom instruction: converts two RGB565 pixels per PUSH to gray, packs four gray bytes per
// word into a FIFO, and serves POP/STATUS/CLEAR. GRAYSCALE_PACKER_ROUND_EN enables rounding.
module grayscale_packer_ise
    import grayscale_packer_pkg::*;
#(
    parameter logic [7:0]  customInstructionId = 8'd0,
    parameter int unsigned FIFO_DEPTH          = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    state_t             r_state;
    logic [1:0]         r_op;
    logic [DATA_W-1:0]  r_pix;
    logic [GRAY_W-1:0]  r_gray0;
    logic [GRAY_W-1:0]  r_gray1;
    logic [15:0]        r_hold;
    logic               r_pending;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_fifo_push;
    logic               w_fifo_pop;
    logic               w_fifo_clear;
    logic [DATA_W-1:0]  w_fifo_out;
    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [DATA_W-1:0]  w_word;
    logic [DATA_W-1:0]  w_status;
    logic               w_unused;

    assign w_unused     = ^valueB[29:0];
    assign w_word       = {r_gray1, r_gray0, r_hold};
    // FIFO side effects are gated by reset so an abandoned op never lands in the FIFO
    assign w_fifo_push  = (r_state == S_WRITE) && r_pending && !reset;
    assign w_fifo_pop   = (r_state == S_RESP) && (r_op == OP_POP) && !reset;
    assign w_fifo_clear = (r_state == S_RESP) && (r_op == OP_CLEAR) && !reset;

    // STATUS word assembly
    always_comb begin
        w_status                = '0;
        w_status[CNT_W-1:0]     = w_fifo_count;
        w_status[ST_PENDING]    = r_pending;
        w_status[ST_FULL]       = w_fifo_full;
        w_status[ST_EMPTY]      = w_fifo_empty;
        w_status[ST_OVERFLOW]   = r_overflow;
        w_status[ST_UNDERFLOW]  = r_underflow;
    end

    gray_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_clear (w_fifo_clear),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_data  (w_word),
        .o_data  (w_fifo_out),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Instruction FSM with registered done/result
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_PUSH;
            r_pix       <= '0;
            r_gray0     <= '0;
            r_gray1     <= '0;
            r_hold      <= '0;
            r_pending   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
        end else begin
            done   <= 1'b0;
            result <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start && (iseId == customInstructionId)) begin
                        r_op    <= valueB[31:30];
                        r_pix   <= valueA;
                        r_state <= (valueB[31:30] == OP_PUSH) ? S_CONVERT : S_RESP;
                    end
                end
                S_CONVERT: begin
                    r_gray0 <= rgb565_to_gray(r_pix[15:0]);
                    r_gray1 <= rgb565_to_gray(r_pix[31:16]);
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (!r_pending) begin
                        r_hold    <= {r_gray1, r_gray0};
                        r_pending <= 1'b1;
                    end else begin
                        r_pending <= 1'b0;
                        if (w_fifo_full) begin
                            r_overflow <= 1'b1;
                        end
                    end
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_RESP: begin
                    case (r_op)
                        OP_POP: begin
                            if (w_fifo_empty) begin
                                r_underflow <= 1'b1;
                            end else begin
                                result <= w_fifo_out;
                            end
                        end
                        OP_STATUS: begin
                            result <= w_status;
                        end
                        OP_CLEAR: begin
                            r_pending   <= 1'b0;
                            r_overflow  <= 1'b0;
                            r_underflow <= 1'b0;
                        end
                        default: begin
                            result <= '0;
                        end
                    endcase
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grayscale_packer_ise.sv
// Scoreboard bench for grayscale_packer_ise (FIFO_DEPTH=4, id 8'h05).
module tb_grayscale_packer_ise;

    localparam logic [7:0] ID = 8'h05;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  iseId;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    logic [1:0] op_push   = 2'b00;
    logic [1:0] op_pop    = 2'b01;
    logic [1:0] op_status = 2'b10;
    logic [1:0] op_clear  = 2'b11;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   n_done = 0;

    grayscale_packer_ise #(
        .customInstructionId (ID),
        .FIFO_DEPTH          (4)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .iseId  (iseId),
        .valueA (valueA),
        .valueB (valueB),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Monitor: pop and compare on every done pulse, including completion cycle
    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1) begin
            n_done++;
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: result=%h at cycle %0d, no op outstanding", result, cyc);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL %s: got result=%h cycle=%0d, expected result=%h cycle=%0d",
                             e.tag, result, cyc, e.res, e.due);
                end
            end
        end else if (done !== 1'b0 || result !== 32'h0) begin
            n_bad++;
            $display("FAIL idle_outputs: done=%b result=%h, expected done=0 result=0 at cycle %0d",
                     done, result, cyc);
        end
    end

    // Reference gray value straight from the channel weights
    function automatic logic [7:0] gray_ref(input logic [15:0] p);
        int s;
        s = int'(p[15:11]) * 8 * 54 + int'(p[10:5]) * 4 * 183 + int'(p[4:0]) * 8 * 19;
`ifdef GRAYSCALE_PACKER_ROUND_EN
        s = s + 128;
`endif
        return 8'(s >>> 8);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: %0d expected responses never arrived", sb.size());
            sb.delete();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // Issue one op; response expected lat cycles after the sampling edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] er,
                         input int lat, input string tag);
        exp_t e;
        @(negedge clock);
        iseId  = ID;
        valueA = a;
        valueB = {op, 30'h1555_5555};
        start  = 1'b1;
        e.res  = er;
        e.due  = cyc + 1 + lat;
        e.tag  = tag;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
        wait_drain();
    endtask

    logic [31:0] pv [10];
    logic [31:0] words [5];
    logic [31:0] white_word;
    int          d0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        iseId  = 8'h00;
        valueA = 32'h0;
        valueB = 32'h0;
        pv = '{32'h07E0_F800, 32'h0000_001F, 32'hFFFF_0000, 32'h1234_5678, 32'h8410_4208,
               32'hF81F_07FF, 32'hABCD_EF01, 32'h0841_1082, 32'h7BEF_39E7, 32'hC618_FFE0};
        for (int k = 0; k < 5; k++) begin
            words[k] = {gray_ref(pv[2*k+1][31:16]), gray_ref(pv[2*k+1][15:0]),
                        gray_ref(pv[2*k][31:16]), gray_ref(pv[2*k][15:0])};
        end
`ifdef GRAYSCALE_PACKER_ROUND_EN
        white_word = 32'hFBFB_FBFB;
`else
        white_word = 32'hFAFA_FAFA;
`endif
        idle(3);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_result", result, 32'h0);
        reset = 1'b0;
        issue(op_status, 32'h0, 32'h0000_0400, 1, "status_after_reset");

        // Basic pair of pushes
        issue(op_push, 32'h07E0_F800, 32'h0, 2, "push_rg");
        issue(op_push, 32'h0000_001F, 32'h0, 2, "push_b");
        issue(op_pop, 32'h0, 32'h0012_B434, 1, "pop_rgb");

        // White saturates the weighted sum
        issue(op_push, 32'hFFFF_FFFF, 32'h0, 2, "push_white0");
        issue(op_push, 32'hFFFF_FFFF, 32'h0, 2, "push_white1");
        issue(op_pop, 32'h0, white_word, 1, "pop_white");

        // Half-word pending then CLEAR
        issue(op_push, 32'h1234_5678, 32'h0, 2, "push_single");
        issue(op_status, 32'h0, 32'h0000_0500, 1, "status_pending");
        issue(op_clear, 32'hDEAD_BEEF, 32'h0, 1, "clear_pending");
        issue(op_status, 32'h0, 32'h0000_0400, 1, "status_cleared");

        // Wrong id must be ignored
        d0 = n_done;
        @(negedge clock);
        iseId  = 8'h06;
        valueA = 32'hFFFF_FFFF;
        valueB = 32'h0;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        idle(5);
        chk("wrong_id_no_done", 32'(n_done - d0), 32'h0);
        issue(op_status, 32'h0, 32'h0000_0400, 1, "status_wrong_id");

        // Overflow a depth-4 FIFO with 10 pushes (5 words)
        for (int k = 0; k < 10; k++) issue(op_push, pv[k], 32'h0, 2, "push_fill");
        issue(op_status, 32'h0, 32'h0000_0A04, 1, "status_full_ovf");
        for (int k = 0; k < 4; k++) issue(op_pop, 32'h0, words[k], 1, "pop_order");
        issue(op_status, 32'h0, 32'h0000_0C00, 1, "status_drained");

        // Underflow
        issue(op_clear, 32'h0, 32'h0, 1, "clear_before_uf");
        issue(op_pop, 32'h0, 32'h0, 1, "pop_empty");
        issue(op_status, 32'h0, 32'h0000_1400, 1, "status_underflow");
        issue(op_clear, 32'h0, 32'h0, 1, "clear_uf");
        issue(op_status, 32'h0, 32'h0000_0400, 1, "status_after_clear");

        // Reset during CONVERT abandons the push
        issue(op_push, 32'h07E0_F800, 32'h0, 2, "push_before_rst");
        d0 = n_done;
        @(negedge clock);
        iseId  = ID;
        valueA = 32'h0000_001F;
        valueB = 32'h0;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        idle(5);
        chk("reset_mid_no_done", 32'(n_done - d0), 32'h0);
        issue(op_status, 32'h0, 32'h0000_0400, 1, "status_after_mid_rst");

        // start held through CONVERT and WRITE: exactly one completion
        d0 = n_done;
        @(negedge clock);
        begin
            exp_t e;
            iseId  = ID;
            valueA = 32'hF800_07E0;
            valueB = 32'h0;
            start  = 1'b1;
            e.res  = 32'h0;
            e.due  = cyc + 3;
            e.tag  = "push_held_start";
            sb.push_back(e);
        end
        idle(3);
        start = 1'b0;
        wait_drain();
        idle(5);
        chk("held_start_one_done", 32'(n_done - d0), 32'h1);
        issue(op_status, 32'h0, 32'h0000_0500, 1, "status_held_start");

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
